fifo_packer: RTL

Write-side counterpart of the FIFO byte reader. Accepts a byte stream (UART receive path toward the WM8731 DSP chain), pairs consecutive bytes into 16-bit samples, and pushes each completed word into the sample FIFO through a single-entry holding register with full-flag back-pressure. An optional inter-byte timeout resynchronises byte pairing after a lost byte.

---
 rtl/fifo_packer.sv | 119 +++++++++++
 1 files changed

// File: rtl/fifo_packer.sv
// Pairs a byte stream into 16-bit words and writes them to a FIFO through a one-entry holding register.
// Optional inter-byte timeout resync is enabled by defining FIFO_PACKER_TIMEOUT_EN.
//
// state      | meaning
// -----------+---------------------------------------------
// IDLE       | no byte held, next byte is the first of a pair
// HAVE_FIRST | first byte held, waiting for the second
module fifo_packer #(
    parameter int MSB_FIRST = 1,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic        fifo_full,
    output logic        o_wr_en,
    output logic [15:0] o_data,
    output logic        o_busy,
    output logic        o_drop,
    output logic [7:0]  o_drop_cnt,
    output logic        o_resync
);

    typedef enum logic {IDLE, HAVE_FIRST} state_t;

    state_t      state, state_nxt;
    logic [7:0]  first_q;
    logic        pending;
    logic        word_done;
    logic        timeout_hit;
    logic        drop_now;
    logic [15:0] word;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("fifo_packer: TIMEOUT must be >= 2");
    end

    assign word     = (MSB_FIRST != 0) ? {first_q, i_data} : {i_data, first_q};
    assign o_wr_en  = pending & ~fifo_full;
    assign o_busy   = (state == HAVE_FIRST);
    assign drop_now = word_done & pending & ~o_wr_en;

    always_comb begin
        state_nxt = state;
        word_done = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) state_nxt = HAVE_FIRST;
            end
            HAVE_FIRST: begin
                if (i_valid) begin
                    state_nxt = IDLE;
                    word_done = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            first_q <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == IDLE && i_valid) first_q <= i_data;
        end
    end

    // A word may enter the holding register in the same cycle the previous one leaves it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending    <= 1'b0;
            o_data     <= 16'h0000;
            o_drop     <= 1'b0;
            o_drop_cnt <= 8'h00;
        end else begin
            o_drop <= drop_now;
            if (word_done && (!pending || o_wr_en)) begin
                pending <= 1'b1;
                o_data  <= word;
            end else if (o_wr_en) begin
                pending <= 1'b0;
            end
            if (drop_now && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'h01;
        end
    end

`ifdef FIFO_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] timer;
    logic          timer_tc;

    // Loaded with TIMEOUT-1 on the first byte; the terminal count is the last edge the pair may complete on.
    assign timer_tc    = (timer == '0);
    assign timeout_hit = timer_tc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer    <= '0;
            o_resync <= 1'b0;
        end else begin
            o_resync <= (state == HAVE_FIRST) && !i_valid && timer_tc;
            if (state == IDLE && i_valid)
                timer <= TW'(TIMEOUT - 1);
            else if (state == HAVE_FIRST && !i_valid && !timer_tc)
                timer <= timer - 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_resync    = 1'b0;
`endif

endmodule
